// File: rtl/if_id_skid_stage.sv
// IF/ID boundary: two-entry skid buffer between fetch and decode, exposing decoded instruction fields.
// Optional decode-stall counter is built when IF_ID_STALL_CNT_EN is defined.
module if_id_skid_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc_plus4,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm16,
  output logic [15:0]     stall_cnt
);

  // State bits are {main_v, skid_v}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_consume;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid;
  logic [PC_W-1:0]   w_pc_plus4;

  logic [31:0]       r_main_instr;
  logic [PC_W-1:0]   r_main_pc4;
  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc4;

  // Handshakes decoded straight from the state so in_ready never depends on out_ready.
  assign w_accept   = in_valid && (r_state != S_FULL);
  assign w_consume  = out_ready && (r_state != S_EMPTY);
  assign w_pc_plus4 = in_pc + PC_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_next = S_ONE;
        S_ONE: begin
          if (w_accept && !w_consume)      w_next = S_FULL;
          else if (!w_accept && w_consume) w_next = S_EMPTY;
        end
        S_FULL:  if (w_consume) w_next = S_ONE;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready       = !r_state[0];
    out_valid      = r_state[1];
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_EMPTY: w_ld_main_in = w_accept;
      S_ONE: begin
        w_ld_main_in = w_accept && w_consume;
        w_ld_skid    = w_accept && !w_consume;
      end
      S_FULL:  w_ld_main_skid = w_consume;
      default: ;
    endcase
  end

  // Data is loaded even during flush; the cleared valid bits make it harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_instr <= '0;
      r_main_pc4   <= '0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_instr <= in_instr;
        r_main_pc4   <= w_pc_plus4;
      end else if (w_ld_main_skid) begin
        r_main_instr <= r_skid_instr;
        r_main_pc4   <= r_skid_pc4;
      end
      if (w_ld_skid) begin
        r_skid_instr <= in_instr;
        r_skid_pc4   <= w_pc_plus4;
      end
    end
  end

  assign out_instr    = r_main_instr;
  assign out_pc_plus4 = r_main_pc4;
  assign out_opcode   = r_main_instr[31:26];
  assign out_rs       = r_main_instr[25:21];
  assign out_rt       = r_main_instr[20:16];
  assign out_rd       = r_main_instr[15:11];
  assign out_shamt    = r_main_instr[10:6];
  assign out_funct    = r_main_instr[5:0];
  assign out_imm16    = r_main_instr[15:0];

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush)   r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: queue-based reference model checked every cycle, plus literal spot checks.
module tb_if_id_skid_stage;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc_plus4;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm16;
  logic [15:0]     stall_cnt;

  int errors = 0;
  int checks = 0;

  if_id_skid_stage #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef IF_ID_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered FIFO of at most two entries.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc4;
  } entry_t;
  entry_t m_q[$];
  int     m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      automatic bit acc  = in_valid && (m_q.size() < 2);
      automatic bit cons = (m_q.size() > 0) && out_ready;
      if (CNT_EN && m_q.size() > 0 && !out_ready && !flush && m_cnt < 65535) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (cons) void'(m_q.pop_front());
        if (acc) m_q.push_back('{instr: in_instr, pc4: in_pc + 32'd4});
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (m_q.size() > 0) begin
      automatic logic [31:0] e = m_q[0].instr;
      check("out_instr", 64'(out_instr), 64'(e));
      check("out_pc_plus4", 64'(out_pc_plus4), 64'(m_q[0].pc4));
      check("fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm16},
            {e >> 26, (e >> 21) & 32'h1F, (e >> 16) & 32'h1F, (e >> 11) & 32'h1F,
             (e >> 6) & 32'h1F, e & 32'h3F, e & 32'hFFFF} == 0 ? 64'd0 :
            {e[31:26], e[25:21], e[20:16], e[15:11], e[10:6], e[5:0], e[15:0]});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_instr", 64'(out_instr), 64'd0);
    check("rst out_pc_plus4", 64'(out_pc_plus4), 64'd0);
    check("rst fields", {out_opcode, out_rs, out_imm16}, 64'd0);
    check("rst stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single lw instruction
    in_valid = 1'b1; in_instr = 32'h8C220004; in_pc = 32'h00400000; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("lw out_valid", 64'(out_valid), 64'd1);
    check("lw opcode", 64'(out_opcode), 64'h23);
    check("lw rs", 64'(out_rs), 64'd1);
    check("lw rt", 64'(out_rt), 64'd2);
    check("lw imm16", 64'(out_imm16), 64'h0004);
    check("lw pc_plus4", 64'(out_pc_plus4), 64'h00400004);
    cycle();

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = 32'h20000000 + 32'(i) * 32'h01010101; in_pc = 32'h1000 + 32'(4 * i);
      check("stream in_ready", 64'(in_ready), 64'd1);
      cycle();
      check("stream out_instr", 64'(out_instr), 64'(32'h20000000 + 32'(i) * 32'h01010101));
      check("stream pc_plus4", 64'(out_pc_plus4), 64'(32'h1004 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: A, B buffered, C waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hAAAA0001; in_pc = 32'h2000;
    cycle();
    in_instr = 32'hBBBB0002; in_pc = 32'h2004;
    cycle();
    in_instr = 32'hCCCC0003; in_pc = 32'h2008;
    cycle();
    check("full in_ready", 64'(in_ready), 64'd0);
    check("full out_instr", 64'(out_instr), 64'hAAAA0001);
    cycle(); cycle(); cycle();
    check("stall_cnt after 5", 64'(stall_cnt), CNT_EN ? 64'd5 : 64'd0);
    out_ready = 1'b1;
    cycle();
    check("drain B", 64'(out_instr), 64'hBBBB0002);
    check("drain in_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    check("drain C", 64'(out_instr), 64'hCCCC0003);
    check("drain C pc4", 64'(out_pc_plus4), 64'h200C);
    cycle();
    check("drained", 64'(out_valid), 64'd0);

    // Flush while FULL with a new instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h11110001; in_pc = 32'h3000;
    cycle();
    in_instr = 32'h22220002; in_pc = 32'h3004;
    cycle();
    in_instr = 32'h33330003; in_pc = 32'h3008; flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'h44440004; in_pc = 32'h300C;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    check("post-flush instr", 64'(out_instr), 64'h44440004);
    cycle();

    // PC wrap
    in_valid = 1'b1; in_instr = 32'h03E00008; in_pc = 32'hFFFFFFFC;
    cycle();
    in_valid = 1'b0;
    check("wrap pc_plus4", 64'(out_pc_plus4), 64'h0);
    check("wrap funct", 64'(out_funct), 64'h08);
    cycle();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h55550005; in_pc = 32'h4000;
    cycle();
    in_instr = 32'h66660006; in_pc = 32'h4004;
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst stall_cnt", 64'(stall_cnt), 64'd0);
    check("async rst out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h77770007; in_pc = 32'h5000;
    cycle();
    in_valid = 1'b0;
    check("post-rst instr", 64'(out_instr), 64'h77770007);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
